// File: rtl/capture_pkg.sv
// Shared definitions for the capture sequencer cluster: state encoding and channel count.
package capture_pkg;

    localparam int NUM_CH = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARB    = 3'd1,
        WAIT   = 3'd2,
        STROBE = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/capture_rr_arb.sv
// Two-way round-robin pick: a lone requester always wins; on contention rr_ptr decides.
module capture_rr_arb
    import capture_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic              rr_ptr,
    output logic [NUM_CH-1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = rr_ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/capture_sched.sv
// Sequencer/arbiter sharing one strobe-and-hold capture path between two requesters.
// Optional capture/abort statistics counters are enabled by defining CAPTURE_SCHED_STATS_EN.
module capture_sched
    import capture_pkg::*;
#(
    parameter int DATA_W  = 1,
    parameter int DELAY_W = 8
`ifdef CAPTURE_SCHED_STATS_EN
    ,
    parameter int CNT_W   = 16
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_CH-1:0]   req,
    input  logic [DATA_W-1:0]   data0,
    input  logic [DATA_W-1:0]   data1,
    input  logic [DELAY_W-1:0]  delay0,
    input  logic [DELAY_W-1:0]  delay1,
    output logic [NUM_CH-1:0]   gnt,
    output logic [NUM_CH-1:0]   strobe,
    output logic [DATA_W-1:0]   hold_q,
    output logic                busy,
    output logic                done
`ifdef CAPTURE_SCHED_STATS_EN
    ,
    output logic [CNT_W-1:0]    cap_cnt0,
    output logic [CNT_W-1:0]    cap_cnt1,
    output logic [CNT_W-1:0]    abort_cnt
`endif
);

    state_t              state_q;
    state_t              state_d;
    logic [NUM_CH-1:0]   gnt_q;
    logic [NUM_CH-1:0]   pick;
    logic [DELAY_W-1:0]  cnt_q;
    logic [DELAY_W-1:0]  delay_sel;
    logic                rr_ptr;

    capture_rr_arb u_arb (
        .req    (req),
        .rr_ptr (rr_ptr),
        .gnt    (pick)
    );

    assign delay_sel = pick[1] ? delay1 : delay0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            cnt_q   <= '0;
            rr_ptr  <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ARB: begin
                    gnt_q <= pick;
                    cnt_q <= delay_sel;
                end
                WAIT:    cnt_q  <= cnt_q - DELAY_W'(1);
                STROBE:  hold_q <= gnt_q[1] ? data1 : data0;
                // Priority passes to the channel that was not just served.
                DONE:    rr_ptr <= gnt_q[0];
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        gnt     = '0;
        strobe  = '0;
        done    = 1'b0;
        busy    = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (req != '0) state_d = ARB;
            end
            ARB: begin
                gnt = pick;
                if (req == '0)            state_d = IDLE;
                else if (delay_sel == '0) state_d = STROBE;
                else                      state_d = WAIT;
            end
            WAIT: begin
                gnt = gnt_q;
                // A dropped grant wins over an expiring count: no strobe after an abort.
                if ((req & gnt_q) == '0)       state_d = IDLE;
                else if (cnt_q == DELAY_W'(1)) state_d = STROBE;
            end
            STROBE: begin
                gnt     = gnt_q;
                strobe  = gnt_q;
                state_d = DONE;
            end
            DONE: begin
                gnt     = gnt_q;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef CAPTURE_SCHED_STATS_EN
    logic abort_ev;

    assign abort_ev = ((state_q == ARB) && (req == '0)) ||
                      ((state_q == WAIT) && ((req & gnt_q) == '0));

    // Saturating statistics; they never wrap back to zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_cnt0  <= '0;
            cap_cnt1  <= '0;
            abort_cnt <= '0;
        end else begin
            if ((state_q == STROBE) && gnt_q[0] && (cap_cnt0 != '1))
                cap_cnt0 <= cap_cnt0 + CNT_W'(1);
            if ((state_q == STROBE) && gnt_q[1] && (cap_cnt1 != '1))
                cap_cnt1 <= cap_cnt1 + CNT_W'(1);
            if (abort_ev && (abort_cnt != '1))
                abort_cnt <= abort_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_capture_sched.sv
// Self-checking bench for capture_sched: directed scenarios plus randomized requesters,
// compared every cycle against a transaction-timeline reference model.
module tb_capture_sched;

    localparam int DATA_W  = 1;
    localparam int DELAY_W = 8;

    logic               clk    = 1'b0;
    logic               rst_n  = 1'b0;
    logic [1:0]         req    = '0;
    logic [DATA_W-1:0]  data0  = '0;
    logic [DATA_W-1:0]  data1  = '0;
    logic [DELAY_W-1:0] delay0 = '0;
    logic [DELAY_W-1:0] delay1 = '0;
    logic [1:0]         gnt;
    logic [1:0]         strobe;
    logic [DATA_W-1:0]  hold_q;
    logic               busy;
    logic               done;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: a transaction is a timeline of offsets from its arbitration cycle.
    bit mValid  = 1'b0;
    bit mActive = 1'b0;
    int mPos    = 0;
    int mCh     = 0;
    int mDly    = 0;
    int mRr     = 0;
    int mHold   = 0;

    capture_sched #(
        .DATA_W  (DATA_W),
        .DELAY_W (DELAY_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .data0  (data0),
        .data1  (data1),
        .delay0 (delay0),
        .delay1 (delay1),
        .gnt    (gnt),
        .strobe (strobe),
        .hold_q (hold_q),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit rn, input logic [1:0] r, input int d0, input int d1,
                                 input bit x0, input bit x1);
        int eGnt, eStb, eBusy, eDone, eHold;
        bit abortNow, finishNow;
        @(negedge clk);
        rst_n  = rn;
        req    = r;
        delay0 = DELAY_W'(d0);
        delay1 = DELAY_W'(d1);
        data0  = DATA_W'(x0);
        data1  = DATA_W'(x1);
        #1;
        eGnt = 0; eStb = 0; eDone = 0; eBusy = int'(mActive); eHold = mHold;
        abortNow = 1'b0; finishNow = 1'b0;
        if (mActive) begin
            if (mPos == 0) begin
                if (r == 2'b00) abortNow = 1'b1;
                else begin
                    mCh  = (r == 2'b11) ? mRr : (r[1] ? 1 : 0);
                    mDly = (mCh == 1) ? d1 : d0;
                    eGnt = 1 << mCh;
                end
            end else if (mPos <= mDly) begin
                eGnt = 1 << mCh;
                if (!r[mCh]) abortNow = 1'b1;
            end else if (mPos == mDly + 1) begin
                eGnt = 1 << mCh;
                eStb = 1 << mCh;
            end else begin
                eGnt = 1 << mCh;
                eDone = 1;
                finishNow = 1'b1;
            end
        end
        if (mValid) begin
            checkOutput("gnt",    32'(gnt),    32'(eGnt));
            checkOutput("strobe", 32'(strobe), 32'(eStb));
            checkOutput("busy",   32'(busy),   32'(eBusy));
            checkOutput("done",   32'(done),   32'(eDone));
            checkOutput("hold_q", 32'(hold_q), 32'(eHold));
        end
        if (!rn) begin
            mValid = 1'b1; mActive = 1'b0; mRr = 0; mHold = 0;
        end else begin
            if (mActive && mPos == mDly + 1) mHold = (mCh == 1) ? int'(x1) : int'(x0);
            if (finishNow) mRr = 1 - mCh;
            if (!mActive) begin
                if (r != 2'b00) begin
                    mActive = 1'b1;
                    mPos = 0;
                end
            end else if (abortNow || finishNow) mActive = 1'b0;
            else mPos++;
        end
    endtask

    initial begin
        logic [1:0] r;
        int d0, d1;
        $display("[TB] capture_sched bench starting");
        applyStimulus(1'b0, 2'b00, 0, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b00, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 2'b00, 0, 0, 1'b1, 1'b1);

        // Abort in WAIT, then contention must still favour channel 0.
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 2'b01, 10, 0, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b00, 10, 0, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b00, 10, 0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 2'b11, 0, 0, 1'b0, 1'b1);
        applyStimulus(1'b1, 2'b00, 0, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b00, 0, 0, 1'b0, 1'b0);

        // Single request with delay 3, then zero-delay request on channel 1.
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 2'b01, 3, 0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b00, 3, 0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'b10, 0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b00, 0, 0, 1'b0, 1'b0);

        // Continuous contention with alternating data.
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 2'b11, 0, 0, 1'b0, 1'b1);
        applyStimulus(1'b1, 2'b00, 0, 0, 1'b0, 1'b0);

        // Reset in the middle of WAIT.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'b01, 10, 0, 1'b1, 1'b1);
        applyStimulus(1'b0, 2'b01, 10, 0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'b00, 10, 0, 1'b1, 1'b1);

        // All-ones delay.
        for (int i = 0; i < 260; i++) applyStimulus(1'b1, 2'b10, 0, 255, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b00, 0, 0, 1'b0, 1'b0);

        // Randomized requesters with occasional drops and resets.
        r = 2'b00; d0 = 0; d1 = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                r[0] = ~r[0];
                d0 = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 6));
            end
            if ($urandom_range(0, 7) == 0) begin
                r[1] = ~r[1];
                d1 = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 6));
            end
            applyStimulus(($urandom_range(0, 199) != 0), r, d0, d1,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/capture_sched.md
Name: capture_sched

Overview:
- Sequencer and arbiter that shares one strobe-and-hold capture path between two requesters (channel 0 and channel 1).
- Each requester asks for its data bit to be captured after a programmed delay.
- The block arbitrates round-robin, counts the delay, fires a one-cycle rising-edge strobe toward that channel's capture instance, and loads the shared hold register.
- Sits above the per-channel capture modules inside a capture cluster; replaces free-running `#`-delay stimulus with clocked sequencing.

Parameters:
- DATA_W, 1, width of each requester's data and of the hold register.
- DELAY_W, 8, width of per-request delay count (cycles).
- CNT_W, 16, width of capture statistics counters (optional feature only).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- req  input  2  per-channel request, level; held until done with matching gnt
- data0  input  DATA_W  channel 0 data, sampled in STROBE
- data1  input  DATA_W  channel 1 data, sampled in STROBE
- delay0  input  DELAY_W  channel 0 wait cycles, latched at grant
- delay1  input  DELAY_W  channel 1 wait cycles, latched at grant
- gnt  output  2  one-hot grant, held from ARB through DONE
- strobe  output  2  one-hot capture strobe to channel instance, one cycle
- hold_q  output  DATA_W  shared hold register
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse in DONE state

Behaviour:
- Reset, sampled on clk while rst_n=0:
  - state=IDLE; gnt=0, strobe=0, hold_q=0, busy=0, done=0.
  - rr_ptr=0, meaning channel 0 has priority next.
  - Reset mid-operation aborts with no strobe and no done.
- States: IDLE, ARB, WAIT, STROBE, DONE.
- IDLE:
  - If req != 0, go to ARB next cycle; otherwise stay.
- ARB, 1 cycle:
  - Grant goes to the requesting channel; if both request, to channel rr_ptr.
  - Set gnt one-hot and latch delayN into cnt.
  - If latched delay = 0, go to STROBE; else go to WAIT.
  - If req dropped to 0 before ARB evaluates, return to IDLE with gnt=0.
- WAIT:
  - cnt decrements each cycle; leave to STROBE in the cycle cnt reaches 1.
  - Total cycles in WAIT equal the delay.
  - If the granted req deasserts, abort to IDLE next cycle: gnt cleared, no strobe, no done, rr_ptr unchanged.
- STROBE, 1 cycle:
  - strobe[g]=1, and hold_q <= data_g at the end of the cycle.
  - Always proceeds to DONE; a req drop here is ignored.
- DONE, 1 cycle:
  - done=1 with gnt still asserted; rr_ptr <= ~g.
  - Next state IDLE; gnt clears on the next edge.
- Latency from req rising in IDLE, delay=D:
  - ARB at +1; strobe at +2+D; done at +3+D.
  - Minimum IDLE-to-IDLE turnaround is 4 cycles at D=0.
- Requester handshake: drop req in the cycle after seeing done & gnt[g].
- A req still high in the IDLE cycle after DONE is re-arbitrated.
- Fairness: with both requesting continuously, grants alternate 0,1,0,1.
- req changes of the non-granted channel during a transaction have no effect until the next ARB.
- delay = all-ones is legal: WAIT lasts 2^DELAY_W−1 cycles.
- hold_q changes only in STROBE.

Optional Feature:
- Macro: CAPTURE_SCHED_STATS_EN.
- With the macro defined, add outputs cap_cnt0 and cap_cnt1 (each CNT_W wide) and abort_cnt (CNT_W wide).
  - cap_cntN increments on each STROBE for channel N.
  - abort_cnt increments on each WAIT or ARB abort.
  - All counters saturate at all-ones and reset to 0.
- Without the macro: no counters and no counter ports; all other behaviour is identical.

Decomposition:
- Shared package capture_pkg holds:
  - the state encoding, as a typedef or localparams: IDLE=0, ARB=1, WAIT=2, STROBE=3, DONE=4, in a 3-bit field;
  - the constant NUM_CH=2.
- One sub-module is natural: capture_rr_arb, a combinational two-way round-robin pick from req and rr_ptr that outputs a one-hot grant.
- Counter, FSM and hold register stay in capture_sched.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, req=0 → all outputs 0, busy=0 for 10 cycles.
- Single request: req=01, delay0=3, data0=1 → ARB at t+1, strobe=01 at t+5, hold_q=1 from t+6, done at t+6, busy low at t+7.
- Zero delay: req=10, delay1=0, data1=1 → strobe=10 two cycles after req, done the following cycle.
- Contention: req=11 held, delays 0, data0=0, data1=1 → grant order 01,10,01,10; hold_q toggles 0,1,0,1; rr_ptr alternates.
- Abort: req=01, delay0=10, drop req after 4 WAIT cycles → no strobe, no done, back to IDLE; next req=11 grants channel 0 first. With CAPTURE_SCHED_STATS_EN, abort_cnt=1.
- Reset mid-WAIT: rst_n=0 one cycle during WAIT → gnt=0, strobe never pulses, hold_q=0, state IDLE.
